// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
//  Module   : dmem_arbiter_pkg
//  Brief    : Shared memory-map constants and arbiter state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

    // Memory-mapped IO region and its device registers
    localparam logic [31:0] ADDR_IO_BASE = 32'hF000_0000;
    localparam logic [31:0] ADDR_HEX     = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR    = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG    = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY     = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW      = 32'hF000_0014;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_starve_counter.sv
// ============================================================================
//  Module   : starve_counter
//  Brief    : Saturating counter of consecutive denied dbg cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module starve_counter #(
    parameter int CNT_BITS = 3,
    parameter int LIMIT    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_atLimit
);

    localparam logic [CNT_BITS-1:0] c_LIMIT = CNT_BITS'(LIMIT);

    logic [CNT_BITS-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_atLimit = (r_count == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Shares the data-memory port between cpu and dbg with cpu
//             priority, dbg starvation guard, dbg lock and IO write guard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int               DBITS        = 32,
    parameter logic [DBITS-1:0] ADDR_IO_BASE = DBITS'(dmem_arbiter_pkg::ADDR_IO_BASE),
    parameter int               STARVE_LIMIT = 4,
    parameter int               CNT_BITS     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_wr,
    input  logic [DBITS-1:0] cpu_addr,
    input  logic [DBITS-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [DBITS-1:0] cpu_rdata,
    input  logic             dbg_req,
    input  logic             dbg_wr,
    input  logic             dbg_lock,
    input  logic [DBITS-1:0] dbg_addr,
    input  logic [DBITS-1:0] dbg_wdata,
    output logic             dbg_gnt,
    output logic             dbg_rvalid,
    output logic [DBITS-1:0] dbg_rdata,
    output logic             dbg_err,
    output logic             mem_wrtEn,
    output logic [DBITS-1:0] mem_addr,
    output logic [DBITS-1:0] mem_dIn,
    input  logic [DBITS-1:0] mem_dOut,
    output logic             cpu_stall
);

    import dmem_arbiter_pkg::*;

    logic [0:0]       r_state;
    logic [0:0]       w_stateNext;
    logic             w_cpuGnt;
    logic             w_dbgGnt;
    logic             w_atLimit;
    logic             w_dbgIoHit;
    logic             r_cpuRvalid;
    logic             r_dbgRvalid;
    logic             r_dbgErr;
    logic [DBITS-1:0] r_cpuRdata;
    logic [DBITS-1:0] r_dbgRdata;

    starve_counter #(
        .CNT_BITS (CNT_BITS),
        .LIMIT    (STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (reset),
        .i_inc     (dbg_req & ~w_dbgGnt),
        .i_clr     (w_dbgGnt | ~dbg_req),
        .o_atLimit (w_atLimit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Lock is held only while dbg_lock stays high; the release cycle arbitrates normally
    always_comb begin
        w_stateNext = ST_ARB;
        if (dbg_lock && ((r_state == ST_LOCK) || w_dbgGnt)) begin
            w_stateNext = ST_LOCK;
        end
    end

    always_comb begin
        w_cpuGnt = 1'b0;
        w_dbgGnt = 1'b0;
        if ((r_state == ST_LOCK) && dbg_lock) begin
            w_dbgGnt = dbg_req;
        end else if (dbg_req && (w_atLimit || !cpu_req)) begin
            w_dbgGnt = 1'b1;
        end else begin
            w_cpuGnt = cpu_req;
        end
    end

    assign w_dbgIoHit = (dbg_addr >= ADDR_IO_BASE);

    assign mem_addr  = w_dbgGnt ? dbg_addr  : cpu_addr;
    assign mem_dIn   = w_dbgGnt ? dbg_wdata : cpu_wdata;
    assign mem_wrtEn = (w_cpuGnt & cpu_wr) | (w_dbgGnt & dbg_wr & ~w_dbgIoHit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpuRvalid <= 1'b0;
            r_dbgRvalid <= 1'b0;
            r_dbgErr    <= 1'b0;
            r_cpuRdata  <= '0;
            r_dbgRdata  <= '0;
        end else begin
            r_cpuRvalid <= w_cpuGnt & ~cpu_wr;
            r_dbgRvalid <= w_dbgGnt & ~dbg_wr;
            r_dbgErr    <= w_dbgGnt & dbg_wr & w_dbgIoHit;
            if (w_cpuGnt && !cpu_wr) begin
                r_cpuRdata <= mem_dOut;
            end
            if (w_dbgGnt && !dbg_wr) begin
                r_dbgRdata <= mem_dOut;
            end
        end
    end

    assign cpu_gnt    = w_cpuGnt;
    assign dbg_gnt    = w_dbgGnt;
    assign cpu_rvalid = r_cpuRvalid;
    assign dbg_rvalid = r_dbgRvalid;
    assign dbg_err    = r_dbgErr;
    assign cpu_rdata  = r_cpuRdata;
    assign dbg_rdata  = r_dbgRdata;
    assign cpu_stall  = cpu_req & ~w_cpuGnt;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Brief    : Directed vector bench for dmem_arbiter with a small memory model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

    localparam logic [31:0] c_R  = 32'h0000_0100;
    localparam logic [31:0] c_R2 = 32'h0000_0104;
    localparam logic [31:0] c_DB = 32'hDEAD_BEEF;
    localparam logic [31:0] c_CF = 32'hCAFE_F00D;
    localparam logic [31:0] c_Z  = 32'h0;
    localparam int          c_NV = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wr, cpu_gnt, cpu_rvalid, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_wr, dbg_lock, dbg_gnt, dbg_rvalid, dbg_err;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_wrtEn;
    logic [31:0] mem_addr, mem_dIn, mem_dOut;

    logic [31:0] mem [0:255];
    int          nTests = 0;
    int          nFail  = 0;

    typedef struct {
        logic        cReq, cWr;
        logic [31:0] cAddr, cData;
        logic        dReq, dWr, dLock;
        logic [31:0] dAddr, dData;
        logic        eCGnt, eDGnt, eWrtEn, eStall, eCRv, eDRv;
        logic [31:0] eAddr, eRdata;
    } vec_t;

    vec_t vec [c_NV];

    dmem_arbiter u_dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_wr     (dbg_wr),
        .dbg_lock   (dbg_lock),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .dbg_err    (dbg_err),
        .mem_wrtEn  (mem_wrtEn),
        .mem_addr   (mem_addr),
        .mem_dIn    (mem_dIn),
        .mem_dOut   (mem_dOut),
        .cpu_stall  (cpu_stall)
    );

    always #5 clk = ~clk;

    // DataMemory model: combinational read, clocked write, preloaded on reset
    assign mem_dOut = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h40] <= c_DB;
            mem[8'h41] <= c_CF;
        end else if (mem_wrtEn) begin
            mem[mem_addr[9:2]] <= mem_dIn;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setIn(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic dl,
                         input logic [31:0] da, input logic [31:0] dd);
        cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
        dbg_req = dr; dbg_wr = dw; dbg_lock = dl; dbg_addr = da; dbg_wdata = dd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // cReq cWr cAddr cData | dReq dWr dLock dAddr dData | cGnt dGnt wEn stall cRv dRv | addr rdata
        vec[0]  = '{1'b1,1'b0,c_R,c_Z, 1'b0,1'b0,1'b0,c_Z,c_Z,           1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, c_R,  c_Z};
        vec[1]  = '{1'b0,1'b0,c_Z,c_Z, 1'b0,1'b0,1'b0,c_Z,c_Z,           1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, c_Z,  c_DB};
        vec[2]  = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b0,1'b0,c_R2,c_Z,          1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, c_R,  c_Z};
        vec[3]  = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b0,1'b0,c_R2,c_Z,          1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, c_R,  c_DB};
        vec[4]  = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b0,1'b0,c_R2,c_Z,          1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, c_R,  c_DB};
        vec[5]  = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b0,1'b0,c_R2,c_Z,          1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, c_R,  c_DB};
        vec[6]  = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b0,1'b0,c_R2,c_Z,          1'b0,1'b1,1'b0,1'b1,1'b1,1'b0, c_R2, c_DB};
        vec[7]  = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b0,1'b0,c_R2,c_Z,          1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, c_R,  c_CF};
        vec[8]  = '{1'b0,1'b0,c_Z,c_Z, 1'b0,1'b0,1'b0,c_Z,c_Z,           1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, c_Z,  c_DB};
        vec[9]  = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b1,1'b1,32'h0,32'hA0,      1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, c_R,  c_Z};
        vec[10] = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b1,1'b1,32'h0,32'hA0,      1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, c_R,  c_DB};
        vec[11] = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b1,1'b1,32'h0,32'hA0,      1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, c_R,  c_DB};
        vec[12] = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b1,1'b1,32'h0,32'hA0,      1'b1,1'b0,1'b0,1'b0,1'b1,1'b0, c_R,  c_DB};
        vec[13] = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b1,1'b1,32'h0,32'hA0,      1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 32'h0,c_DB};
        vec[14] = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b1,1'b1,32'h4,32'hA4,      1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 32'h4,c_Z};
        vec[15] = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b1,1'b1,32'h8,32'hA8,      1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 32'h8,c_Z};
        vec[16] = '{1'b1,1'b0,c_R,c_Z, 1'b0,1'b0,1'b0,c_Z,c_Z,           1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, c_R,  c_Z};
        vec[17] = '{1'b0,1'b0,c_Z,c_Z, 1'b1,1'b0,1'b1,c_R,c_Z,           1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, c_R,  c_DB};
        vec[18] = '{1'b1,1'b0,c_R,c_Z, 1'b0,1'b0,1'b1,c_Z,c_Z,           1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, c_R,  c_DB};
        vec[19] = '{1'b1,1'b0,c_R,c_Z, 1'b1,1'b0,1'b1,c_R2,c_Z,          1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, c_R2, c_Z};

        reset = 1'b1;
        setIn(1'b0,1'b0,c_Z,c_Z, 1'b0,1'b0,1'b0,c_Z,c_Z);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("reset dbg_rvalid", 32'(dbg_rvalid), 32'h0);
        chk("reset dbg_err",    32'(dbg_err),    32'h0);
        chk("reset cpu_rdata",  cpu_rdata,       32'h0);
        chk("reset dbg_rdata",  dbg_rdata,       32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < c_NV; i++) begin
            setIn(vec[i].cReq, vec[i].cWr, vec[i].cAddr, vec[i].cData,
                  vec[i].dReq, vec[i].dWr, vec[i].dLock, vec[i].dAddr, vec[i].dData);
            #2;
            chk($sformatf("v%0d cpu_gnt", i),    32'(cpu_gnt),    32'(vec[i].eCGnt));
            chk($sformatf("v%0d dbg_gnt", i),    32'(dbg_gnt),    32'(vec[i].eDGnt));
            chk($sformatf("v%0d mem_wrtEn", i),  32'(mem_wrtEn),  32'(vec[i].eWrtEn));
            chk($sformatf("v%0d cpu_stall", i),  32'(cpu_stall),  32'(vec[i].eStall));
            chk($sformatf("v%0d cpu_rvalid", i), 32'(cpu_rvalid), 32'(vec[i].eCRv));
            chk($sformatf("v%0d dbg_rvalid", i), 32'(dbg_rvalid), 32'(vec[i].eDRv));
            chk($sformatf("v%0d mem_addr", i),   mem_addr,        vec[i].eAddr);
            if (vec[i].eCRv) chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vec[i].eRdata);
            if (vec[i].eDRv) chk($sformatf("v%0d dbg_rdata", i), dbg_rdata, vec[i].eRdata);
            nextCycle();
        end

        chk("lock write 0x0", mem[0], 32'hA0);
        chk("lock write 0x4", mem[1], 32'hA4);
        chk("lock write 0x8", mem[2], 32'hA8);

        // Reset while locked with a dbg read pending
        reset = 1'b1;
        #2;
        chk("rst-in-lock dbg_gnt", 32'(dbg_gnt), 32'h1);
        nextCycle();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2;
            if (k == 0) begin
                chk("post-rst dbg_rvalid", 32'(dbg_rvalid), 32'h0);
                chk("post-rst cpu_rvalid", 32'(cpu_rvalid), 32'h0);
                chk("post-rst dbg_rdata",  dbg_rdata,       32'h0);
                chk("post-rst cpu_rdata",  cpu_rdata,       32'h0);
            end
            chk($sformatf("post-rst c%0d cpu_gnt", k), 32'(cpu_gnt), (k < 4) ? 32'h1 : 32'h0);
            chk($sformatf("post-rst c%0d dbg_gnt", k), 32'(dbg_gnt), (k == 4) ? 32'h1 : 32'h0);
            nextCycle();
        end

        setIn(1'b0,1'b0,c_Z,c_Z, 1'b0,1'b0,1'b0,c_Z,c_Z);
        nextCycle();

        // cpu write followed by dbg read of the same word
        setIn(1'b1,1'b1,32'h20,32'hA5, 1'b0,1'b0,1'b0,c_Z,c_Z);
        #2;
        chk("cpu wr cpu_gnt",   32'(cpu_gnt),   32'h1);
        chk("cpu wr mem_wrtEn", 32'(mem_wrtEn), 32'h1);
        chk("cpu wr mem_addr",  mem_addr,       32'h20);
        chk("cpu wr mem_dIn",   mem_dIn,        32'hA5);
        nextCycle();
        setIn(1'b0,1'b0,c_Z,c_Z, 1'b1,1'b0,1'b0,32'h20,c_Z);
        #2;
        chk("dbg rd dbg_gnt",         32'(dbg_gnt),    32'h1);
        chk("dbg rd mem_wrtEn",       32'(mem_wrtEn),  32'h0);
        chk("cpu wr no cpu_rvalid",   32'(cpu_rvalid), 32'h0);
        nextCycle();
        setIn(1'b0,1'b0,c_Z,c_Z, 1'b0,1'b0,1'b0,c_Z,c_Z);
        #2;
        chk("dbg rd dbg_rvalid", 32'(dbg_rvalid), 32'h1);
        chk("dbg rd dbg_rdata",  dbg_rdata,       32'hA5);
        nextCycle();

        // dbg write into the IO region is dropped and flagged
        setIn(1'b0,1'b0,c_Z,c_Z, 1'b1,1'b1,1'b0,32'hF000_0004,32'h5);
        #2;
        chk("io wr dbg_gnt",   32'(dbg_gnt),   32'h1);
        chk("io wr mem_wrtEn", 32'(mem_wrtEn), 32'h0);
        chk("io wr dbg_err0",  32'(dbg_err),   32'h0);
        nextCycle();
        setIn(1'b0,1'b0,c_Z,c_Z, 1'b0,1'b0,1'b0,c_Z,c_Z);
        #2;
        chk("io wr dbg_err1",     32'(dbg_err),    32'h1);
        chk("io wr no dbg_rvalid",32'(dbg_rvalid), 32'h0);
        nextCycle();
        #2;
        chk("io wr dbg_err2",  32'(dbg_err), 32'h0);
        chk("io wr mem intact", mem[1],      32'h0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory/IO port (DataMemory: combinational read, write on clk edge) between two requesters: the processor datapath (cpu) and a debug/loader port (dbg).
- Sits between the processor's aluOut/rs2/dMemWrtEn signals, the debug master and DataMemory.
- Provides fixed CPU priority, a starvation guard for dbg, a dbg lock (burst) mode and write protection of the memory-mapped IO region against dbg.

Parameters:
- DBITS, 32, data and address width.
- ADDR_IO_BASE, 32'hF0000000, addresses >= this value are memory-mapped IO (KEY/SW/HEX/LEDR/LEDG).
- STARVE_LIMIT, 4, consecutive denied dbg cycles before dbg is forced to win.
- CNT_BITS, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock (PLL output).
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  cpu access request this cycle.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  DBITS  byte address.
- cpu_wdata  in  DBITS  write data.
- cpu_gnt  out  1  cpu access performed this cycle (combinational).
- cpu_rvalid  out  1  cpu read data valid (registered).
- cpu_rdata  out  DBITS  cpu read data.
- dbg_req  in  1  dbg access request this cycle.
- dbg_wr  in  1  1 = write, 0 = read.
- dbg_lock  in  1  request exclusive ownership while high.
- dbg_addr  in  DBITS  byte address.
- dbg_wdata  in  DBITS  write data.
- dbg_gnt  out  1  dbg access performed this cycle (combinational).
- dbg_rvalid  out  1  dbg read data valid (registered).
- dbg_rdata  out  DBITS  dbg read data.
- dbg_err  out  1  registered pulse: the previous granted dbg write targeted IO and was dropped.
- mem_wrtEn  out  1  to DataMemory wrtEn.
- mem_addr  out  DBITS  to DataMemory addr.
- mem_dIn  out  DBITS  to DataMemory dIn.
- mem_dOut  in  DBITS  from DataMemory dOut.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes the processor PC write enable.

Behaviour:
- FSM states: ARB and LOCK.
  - ARB -> LOCK when dbg is granted with dbg_lock = 1.
  - LOCK -> ARB on the first cycle with dbg_lock = 0. That cycle is arbitrated as ARB.
- Grant, ARB state:
  - dbg wins if dbg_req and (starve_cnt == STARVE_LIMIT or ~cpu_req).
  - Otherwise cpu wins if cpu_req.
  - At most one grant per cycle.
- Grant, LOCK state: dbg_gnt = dbg_req & dbg_lock; cpu_gnt = 0.
  - A cycle in LOCK with dbg_lock = 1 and no dbg_req grants nothing and the state stays LOCK.
- Mux: mem_addr and mem_dIn come from the granted requester.
  - With no grant they carry the cpu values and mem_wrtEn = 0.
- mem_wrtEn = grant & wr of the granted requester.
  - Exception: a dbg write with dbg_addr >= ADDR_IO_BASE (unsigned) forces mem_wrtEn = 0. dbg_err = 1 on the next cycle for exactly 1 cycle.
- Reads, 1-cycle latency:
  - On a granted read, mem_dOut is registered into <req>_rdata and <req>_rvalid = 1 on the next cycle only.
  - rdata holds its value until the next granted read by the same requester.
  - Writes never raise rvalid.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each cycle with dbg_req & ~dbg_gnt.
  - Clears on dbg_gnt or when dbg_req = 0.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: cpu wins.
- Writes and reads to the same address on consecutive cycles by different requesters are ordered by grant order.
- Reset (synchronous, takes priority over all else):
  - State = ARB; starve_cnt = 0.
  - cpu_rvalid, dbg_rvalid, dbg_err = 0; cpu_rdata, dbg_rdata = 0.
  - Grant outputs follow the combinational rules from the reset values.
  - Reset asserted in LOCK returns to ARB; any read granted in the reset cycle does not produce rvalid.

Decomposition:
- Shared package (project constants, e.g. in the existing params include):
  - ADDR_IO_BASE and the ADDR_KEY/SW/HEX/LEDR/LEDG constants.
  - State encoding localparams ST_ARB = 1'b0, ST_LOCK = 1'b1.
- One natural sub-module: starve_counter (saturating counter with inc/clr, parameter CNT_BITS/LIMIT, output at_limit).

Test Plan:
- Only cpu reads 0x100 with mem_dOut = 32'hDEADBEEF -> cpu_gnt = 1 same cycle; next cycle cpu_rvalid = 1, cpu_rdata = DEADBEEF, dbg_rvalid = 0.
- cpu_req and dbg_req held high for 6 cycles -> cpu granted cycles 0-3, dbg granted cycle 4 (starve_cnt hit 4), cpu cycle 5; cpu_stall = 1 only in cycle 4.
- dbg writes 32'h5 to 0xF0000004 -> mem_wrtEn = 0, dbg_gnt = 1; next cycle dbg_err = 1 for one cycle; memory unchanged.
- dbg_lock = 1 with 3 dbg writes to 0x0, 0x4, 0x8 while cpu_req = 1 -> cpu_gnt = 0 throughout; mem_wrtEn = 1 each cycle. After dbg_lock drops, cpu is granted on that cycle.
- Reset asserted for 1 cycle while in LOCK with a pending dbg read -> next cycle state ARB, dbg_rvalid = 0, rdata = 0, starve_cnt = 0.
- cpu write 32'hA5 to 0x20, then next cycle dbg read 0x20 (cpu_req = 0) -> dbg_rdata = 32'hA5 one cycle later.
